// File: rtl/fib_term_buffer.sv
// Samples a free-running Fibonacci term stream, checks each sample against the
// recurrence, and queues {term, capture index} pairs in a FIFO drained by valid/ready.
module fib_term_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           fib_in,
  input  logic                       capture,
  output logic [WIDTH-1:0]           out_data,
  output logic [7:0]                 out_index,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       seq_err,
  output logic                       ovf,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {CK_EMPTY, CK_ONE, CK_RUN} ck_state_t;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [7:0]       idx_mem  [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [7:0]       cap_idx;
  logic [CW-1:0]    count_next;
  logic             push, pop, drop;

  ck_state_t        state, state_next;
  logic [WIDTH-1:0] h0, h1, h0_next, h1_next, pair_sum;
  logic             seq_hit, ovf_hit;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A pop on the same edge frees a slot, so a full FIFO can still accept a push.
  assign push      = capture & (~full | pop);
  assign drop      = capture & ~push;

  assign out_data  = out_valid ? data_mem[rd_ptr] : '0;
  assign out_index = out_valid ? idx_mem[rd_ptr]  : '0;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  assign pair_sum = h0 + h1;

  // Any capture gap breaks adjacency with the generator, so history restarts.
  always_comb begin
    state_next = CK_EMPTY;
    h0_next    = h0;
    h1_next    = h1;
    seq_hit    = 1'b0;
    ovf_hit    = 1'b0;
    if (capture) begin
      case (state)
        CK_EMPTY: begin
          h1_next    = fib_in;
          state_next = CK_ONE;
        end
        CK_ONE: begin
          h0_next    = h1;
          h1_next    = fib_in;
          state_next = CK_RUN;
        end
        CK_RUN: begin
          seq_hit    = (fib_in != pair_sum);
          ovf_hit    = (fib_in < h1);
          h0_next    = h1;
          h1_next    = fib_in;
          state_next = CK_RUN;
        end
        default: state_next = CK_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      cap_idx  <= '0;
      drop_cnt <= '0;
      seq_err  <= 1'b0;
      ovf      <= 1'b0;
      state    <= CK_EMPTY;
      h0       <= '0;
      h1       <= '0;
    end else begin
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (capture) cap_idx <= cap_idx + 8'd1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (seq_hit) seq_err <= 1'b1;
      if (ovf_hit) ovf <= 1'b1;
      state <= state_next;
      h0    <= h0_next;
      h1    <= h1_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      data_mem[wr_ptr] <= fib_in;
      idx_mem[wr_ptr]  <= cap_idx;
    end
  end

endmodule
